// File: rtl/ppu_fetch_tap_if.sv
// ----------------------------------------------------------------------------
// ppu_fetch_tap_if
// Bus bundle between a PPU-bus source and the ppu_fetch_tap observer.
//   ppu_oe      raw PPU read strobe, active low, asynchronous to clk
//   ppu_addr    raw 14-bit PPU address bus
//   fetch_vld   1-clk pulse, one per completed valid read
//   fetch_addr  captured address, held until the next capture
//   fetch_kind  0 pattern, 1 nametable, 2 attribute, 3 palette
//   tile_evt    1-clk pulse coincident with fetch_vld on a $FD/$FE tile fetch
//   tile_tbl    pattern table of the tile event
//   tile_val    0 = tile $FD, 1 = tile $FE
// master: drives the PPU bus and consumes events. slave: the observer.
// ----------------------------------------------------------------------------
interface ppu_fetch_tap_if;
  logic        ppu_oe;
  logic [13:0] ppu_addr;
  logic        fetch_vld;
  logic [13:0] fetch_addr;
  logic [1:0]  fetch_kind;
  logic        tile_evt;
  logic        tile_tbl;
  logic        tile_val;

  modport master (
    output ppu_oe,
    output ppu_addr,
    input  fetch_vld,
    input  fetch_addr,
    input  fetch_kind,
    input  tile_evt,
    input  tile_tbl,
    input  tile_val
  );

  modport slave (
    input  ppu_oe,
    input  ppu_addr,
    output fetch_vld,
    output fetch_addr,
    output fetch_kind,
    output tile_evt,
    output tile_tbl,
    output tile_val
  );
endinterface

// File: rtl/ppu_fetch_tap.sv
// ----------------------------------------------------------------------------
// ppu_fetch_tap
// Observes the PPU bus for CHR-latch mappers (MMC2/MMC4 class). The raw read
// strobe is synchronised into the clk domain; a read whose strobe stays low
// for SETTLE synchronised cycles has its address captured and classified,
// and produces one fetch event when the strobe returns high. Completed
// high-plane pattern fetches of tiles $FD/$FE also raise a tile event.
// Reads that end before SETTLE cycles are runts: they are counted, not
// reported.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        ppu_fetch_tap_if.slave (PPU strobe/address in, events out)
//   sst_act    save-state active; masks fetch_vld/tile_evt only
//   short_clr  synchronous clear of short_cnt
//   short_cnt  saturating count of runt reads
// ----------------------------------------------------------------------------
module ppu_fetch_tap #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 3,
  parameter bit EXACT_LO    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  ppu_fetch_tap_if.slave    bus,
  input  logic              sst_act,
  input  logic              short_clr,
  output logic [7:0]        short_cnt
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  // Address class of a PPU fetch. Palette is tested before attribute so
  // that $3FC0-$3FFF is reported as palette.
  function automatic logic [1:0] classify(input logic [13:0] a);
    logic [1:0] k;
    if (a[13] == 1'b0) begin
      k = 2'd0;
    end else if (a[13:8] == 6'h3F) begin
      k = 2'd3;
    end else if (a[9:6] == 4'hF) begin
      k = 2'd2;
    end else begin
      k = 2'd1;
    end
    return k;
  endfunction

  // High-plane pattern fetch of tile $FD or $FE. With EXACT_LO, table 0
  // only latches on row 0, matching the MMC2 $0FD8/$0FE8 behaviour.
  function automatic logic tile_hit(input logic [13:0] a);
    logic hit;
    hit = (classify(a) == 2'd0) && (a[3] == 1'b1) &&
          ((a[11:4] == 8'hFD) || (a[11:4] == 8'hFE));
    if ((EXACT_LO == 1'b1) && (a[12] == 1'b0) && (a[2:0] != 3'd0)) begin
      hit = 1'b0;
    end else begin
      hit = hit;
    end
    return hit;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   oe_d_r;
  logic                   oe_s;
  logic                   fall_s;
  logic                   rise_s;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [3:0]  low_cnt_r;
  logic [3:0]  low_cnt_nxt_s;
  logic        capture_s;
  logic        fire_s;
  logic        runt_s;

  logic        fetch_vld_r;
  logic [13:0] fetch_addr_r;
  logic [1:0]  fetch_kind_r;
  logic        tile_evt_r;
  logic        tile_tbl_r;
  logic        tile_val_r;
  logic        tile_hit_r;
  logic [1:0]  cap_kind_s;
  logic        cap_hit_s;
  logic        tile_now_s;

  logic [7:0]  short_cnt_r;
  logic [7:0]  short_base_s;
  logic [7:0]  short_nxt_s;

  // Strobe synchroniser plus one delay stage for edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      oe_d_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ppu_oe};
      oe_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign oe_s   = sync_r[SYNC_STAGES-1];
  assign fall_s = ~oe_s & oe_d_r;
  assign rise_s = oe_s & ~oe_d_r;

  // Read-tracking FSM. A read that reaches SETTLE low cycles is captured;
  // if the strobe rises in that same cycle the read is complete and fires
  // immediately instead of passing through ARMED.
  always_comb begin
    state_nxt_s   = state_r;
    low_cnt_nxt_s = low_cnt_r;
    capture_s     = 1'b0;
    fire_s        = 1'b0;
    runt_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s   = ST_LOW;
          low_cnt_nxt_s = 4'd1;
        end else begin
          low_cnt_nxt_s = 4'd0;
        end
      end
      ST_LOW: begin
        if (low_cnt_r == SETTLE_C) begin
          capture_s = 1'b1;
          if (rise_s) begin
            fire_s        = 1'b1;
            state_nxt_s   = ST_IDLE;
            low_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s   = ST_ARMED;
          end
        end else if (rise_s) begin
          runt_s        = 1'b1;
          state_nxt_s   = ST_IDLE;
          low_cnt_nxt_s = 4'd0;
        end else begin
          low_cnt_nxt_s = low_cnt_r + 4'd1;
        end
      end
      ST_ARMED: begin
        // low_cnt stays saturated at SETTLE until the read completes.
        if (rise_s) begin
          fire_s        = 1'b1;
          state_nxt_s   = ST_IDLE;
          low_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s   = ST_ARMED;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        low_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // FSM state and low-time counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      low_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      low_cnt_r <= low_cnt_nxt_s;
    end
  end

  // Classification of the address being captured this cycle; when capture
  // and completion coincide, the fresh tile decision must be used.
  always_comb begin
    cap_kind_s = classify(bus.ppu_addr);
    cap_hit_s  = tile_hit(bus.ppu_addr);
    if (capture_s) begin
      tile_now_s = cap_hit_s;
    end else begin
      tile_now_s = tile_hit_r;
    end
  end

  // Event pulses and captured fields. Capture keeps running under sst_act;
  // only the pulses are masked, so a read completing then is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_vld_r  <= 1'b0;
      tile_evt_r   <= 1'b0;
      fetch_addr_r <= 14'd0;
      fetch_kind_r <= 2'd0;
      tile_hit_r   <= 1'b0;
      tile_tbl_r   <= 1'b0;
      tile_val_r   <= 1'b0;
    end else begin
      fetch_vld_r <= fire_s & ~sst_act;
      tile_evt_r  <= fire_s & ~sst_act & tile_now_s;
      if (capture_s) begin
        fetch_addr_r <= bus.ppu_addr;
        fetch_kind_r <= cap_kind_s;
        tile_hit_r   <= cap_hit_s;
        if (cap_hit_s) begin
          tile_tbl_r <= bus.ppu_addr[12];
          tile_val_r <= (bus.ppu_addr[11:4] == 8'hFE);
        end
      end
    end
  end

  // Runt counter next value: clear first, then a saturating increment.
  always_comb begin
    if (short_clr) begin
      short_base_s = 8'd0;
    end else begin
      short_base_s = short_cnt_r;
    end
    if (runt_s && (short_base_s != 8'hFF)) begin
      short_nxt_s = short_base_s + 8'd1;
    end else begin
      short_nxt_s = short_base_s;
    end
  end

  // Runt counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_cnt_r <= 8'd0;
    end else begin
      short_cnt_r <= short_nxt_s;
    end
  end

  assign bus.fetch_vld  = fetch_vld_r;
  assign bus.fetch_addr = fetch_addr_r;
  assign bus.fetch_kind = fetch_kind_r;
  assign bus.tile_evt   = tile_evt_r;
  assign bus.tile_tbl   = tile_tbl_r;
  assign bus.tile_val   = tile_val_r;
  assign short_cnt      = short_cnt_r;

endmodule

// File: tb/tb_ppu_fetch_tap.sv
// ----------------------------------------------------------------------------
// tb_ppu_fetch_tap
// Two instances share one PPU bus stimulus: u0 with EXACT_LO=0, u1 with
// EXACT_LO=1. A read-level model queues the expected event (due cycle and
// address) whenever a read long enough completes; one compare process
// checks both instances every cycle against that queue.
// ----------------------------------------------------------------------------
module tb_ppu_fetch_tap;
  localparam int SYNC   = 2;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sst_act;
  logic        short_clr;
  logic        ppu_oe;
  logic [13:0] ppu_addr;
  logic [7:0]  short_cnt0;
  logic [7:0]  short_cnt1;

  always #5 clk = ~clk;

  ppu_fetch_tap_if bus0();
  ppu_fetch_tap_if bus1();

  assign bus0.ppu_oe   = ppu_oe;
  assign bus0.ppu_addr = ppu_addr;
  assign bus1.ppu_oe   = ppu_oe;
  assign bus1.ppu_addr = ppu_addr;

  ppu_fetch_tap #(.SYNC_STAGES(SYNC), .SETTLE(SETTLE), .EXACT_LO(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .sst_act(sst_act),
    .short_clr(short_clr), .short_cnt(short_cnt0));

  ppu_fetch_tap #(.SYNC_STAGES(SYNC), .SETTLE(SETTLE), .EXACT_LO(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .sst_act(sst_act),
    .short_clr(short_clr), .short_cnt(short_cnt1));

  typedef struct {
    int          due;
    logic [13:0] addr;
  } ev_t;

  ev_t         evq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          vld_seen = 0;
  int          tile_cnt0 = 0;
  int          tile_cnt1 = 0;
  int          last_vld_cyc = 0;
  int          rise_cyc = 0;
  int          exp_short = 0;
  logic [13:0] exp_addr = 14'd0;
  bit          checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] kind_of(input logic [13:0] a);
    if (!a[13]) return 2'd0;
    if (a[13:8] == 6'h3F) return 2'd3;
    if (a[9:6] == 4'hF) return 2'd2;
    return 2'd1;
  endfunction

  function automatic bit tile_of(input logic [13:0] a, input bit exact);
    if (kind_of(a) != 2'd0 || !a[3]) return 1'b0;
    if (a[11:4] != 8'hFD && a[11:4] != 8'hFE) return 1'b0;
    if (exact && !a[12] && a[2:0] != 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_out(input string tag, input bit exact, input bit due,
                           input logic [13:0] ea, input logic vld, input logic tile,
                           input logic [13:0] addr, input logic [1:0] kind,
                           input logic tbl, input logic val);
    bit exp_tile;
    exp_tile = due && tile_of(ea, exact);
    chk({tag, ".fetch_vld"}, 32'(vld), 32'(due));
    chk({tag, ".tile_evt"}, 32'(tile), 32'(exp_tile));
    if (due) begin
      chk({tag, ".fetch_addr"}, 32'(addr), 32'(ea));
      chk({tag, ".fetch_kind"}, 32'(kind), 32'(kind_of(ea)));
      if (exp_tile) begin
        chk({tag, ".tile_tbl"}, 32'(tbl), 32'(ea[12]));
        chk({tag, ".tile_val"}, 32'(val), 32'(ea[11:4] == 8'hFE));
      end
    end
  endtask

  // Per-cycle comparison of both instances against the event queue.
  always @(negedge clk) begin
    if (checking) begin
      bit          due;
      logic [13:0] ea;
      due = (evq.size() > 0) && (evq[0].due == cyc);
      ea  = due ? evq[0].addr : 14'd0;
      check_out("u0", 1'b0, due, ea, bus0.fetch_vld, bus0.tile_evt, bus0.fetch_addr,
                bus0.fetch_kind, bus0.tile_tbl, bus0.tile_val);
      check_out("u1", 1'b1, due, ea, bus1.fetch_vld, bus1.tile_evt, bus1.fetch_addr,
                bus1.fetch_kind, bus1.tile_tbl, bus1.tile_val);
      if (bus0.fetch_vld === 1'b1) begin
        vld_seen++;
        last_vld_cyc = cyc;
      end
      if (bus0.tile_evt === 1'b1) tile_cnt0++;
      if (bus1.tile_evt === 1'b1) tile_cnt1++;
      if (due) void'(evq.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PPU read: strobe low for len clk with a stable address, then a gap.
  task automatic do_read(input logic [13:0] a, input int len, input bit clr_at_rise);
    ev_t e;
    ppu_addr = a;
    ppu_oe   = 1'b0;
    tick(len);
    ppu_oe   = 1'b1;
    rise_cyc = cyc;
    if (len >= SETTLE) begin
      exp_addr = a;
      if (!sst_act) begin
        e.due  = cyc + SYNC + 1;
        e.addr = a;
        evq.push_back(e);
      end
    end else begin
      if (clr_at_rise) exp_short = 0;
      if (exp_short < 255) exp_short++;
    end
    if (clr_at_rise) begin
      tick(SYNC - 1);
      short_clr = 1'b1;
      tick(1);
      short_clr = 1'b0;
    end
    tick(6);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".u0.fetch_vld"},  32'(bus0.fetch_vld), 32'd0);
    chk({tag, ".u0.tile_evt"},   32'(bus0.tile_evt), 32'd0);
    chk({tag, ".u0.fetch_addr"}, 32'(bus0.fetch_addr), 32'd0);
    chk({tag, ".u0.fetch_kind"}, 32'(bus0.fetch_kind), 32'd0);
    chk({tag, ".u0.tile_tbl"},   32'(bus0.tile_tbl), 32'd0);
    chk({tag, ".u0.tile_val"},   32'(bus0.tile_val), 32'd0);
    chk({tag, ".u0.short_cnt"},  32'(short_cnt0), 32'd0);
    chk({tag, ".u1.fetch_addr"}, 32'(bus1.fetch_addr), 32'd0);
    chk({tag, ".u1.short_cnt"},  32'(short_cnt1), 32'd0);
  endtask

  task automatic check_short(input string tag);
    chk({tag, ".u0.short_cnt"}, 32'(short_cnt0), 32'(exp_short));
    chk({tag, ".u1.short_cnt"}, 32'(short_cnt1), 32'(exp_short));
  endtask

  initial begin
    int v0;
    int t0;
    int t1;
    rst_n     = 1'b0;
    ppu_oe    = 1'b1;
    ppu_addr  = 14'd0;
    sst_act   = 1'b0;
    short_clr = 1'b0;
    tick(3);
    checking = 1'b1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(3);

    // Read of $0FD8 held 8 clk: one event, SYNC+1 clk after the pin rises.
    v0 = vld_seen;
    t0 = tile_cnt0;
    do_read(14'h0FD8, 8, 1'b0);
    chk("t1.vld_count", 32'(vld_seen - v0), 32'd1);
    chk("t1.latency", 32'(last_vld_cyc - rise_cyc), 32'd3);
    chk("t1.tile_count", 32'(tile_cnt0 - t0), 32'd1);
    chk("t1.kind", 32'(bus0.fetch_kind), 32'd0);
    chk("t1.tile_tbl", 32'(bus0.tile_tbl), 32'd0);
    chk("t1.tile_val", 32'(bus0.tile_val), 32'd0);

    // Tile $FE in table 1, then attribute, nametable, palette.
    do_read(14'h1FEB, 5, 1'b0);
    chk("t2.tile_tbl", 32'(bus0.tile_tbl), 32'd1);
    chk("t2.tile_val", 32'(bus0.tile_val), 32'd1);
    t0 = tile_cnt0;
    do_read(14'h23C5, 5, 1'b0);
    chk("t2.kind_attr", 32'(bus0.fetch_kind), 32'd2);
    do_read(14'h2041, 5, 1'b0);
    chk("t2.kind_nt", 32'(bus0.fetch_kind), 32'd1);
    do_read(14'h3F10, 5, 1'b0);
    chk("t2.kind_pal", 32'(bus0.fetch_kind), 32'd3);
    chk("t2.no_tile", 32'(tile_cnt0 - t0), 32'd0);

    // Row-exact matching differs between the two instances.
    t0 = tile_cnt0;
    t1 = tile_cnt1;
    do_read(14'h0FD9, 4, 1'b0);
    chk("t3.u0_tile_0fd9", 32'(tile_cnt0 - t0), 32'd1);
    chk("t3.u1_tile_0fd9", 32'(tile_cnt1 - t1), 32'd0);
    t1 = tile_cnt1;
    do_read(14'h1FD9, 4, 1'b0);
    chk("t3.u1_tile_1fd9", 32'(tile_cnt1 - t1), 32'd1);

    // Exactly SETTLE clk low is still a valid read.
    v0 = vld_seen;
    do_read(14'h2041, SETTLE, 1'b0);
    chk("settle_exact.vld_count", 32'(vld_seen - v0), 32'd1);

    // Runts: one, then saturation, then clear coincident with a runt.
    v0 = vld_seen;
    do_read(14'h1234, SETTLE - 1, 1'b0);
    chk("t4.short_one", 32'(short_cnt0), 32'd1);
    chk("t4.no_vld", 32'(vld_seen - v0), 32'd0);
    chk("t4.addr_kept", 32'(bus0.fetch_addr), 32'h2041);
    for (int i = 0; i < 300; i++) begin
      do_read(14'h1234, 1 + (i % (SETTLE - 1)), 1'b0);
    end
    chk("t4.short_sat", 32'(short_cnt0), 32'd255);
    check_short("t4.sat");
    do_read(14'h1234, SETTLE - 1, 1'b1);
    chk("t4.short_clr_runt", 32'(short_cnt0), 32'd1);
    check_short("t4.clr");

    // Save-state masks pulses but capture continues.
    v0 = vld_seen;
    sst_act = 1'b1;
    do_read(14'h0FE8, 6, 1'b0);
    sst_act = 1'b0;
    chk("t5.no_vld", 32'(vld_seen - v0), 32'd0);
    chk("t5.u0_addr", 32'(bus0.fetch_addr), 32'h0FE8);
    chk("t5.u1_addr", 32'(bus1.fetch_addr), 32'h0FE8);
    chk("t5.model_addr", 32'(bus0.fetch_addr), 32'(exp_addr));
    do_read(14'h0FE8, 6, 1'b0);
    chk("t5.resume_vld", 32'(vld_seen - v0), 32'd1);

    // Reset while ARMED, released with the strobe high: nothing emitted.
    v0 = vld_seen;
    ppu_addr = 14'h0FD8;
    ppu_oe   = 1'b0;
    tick(8);
    rst_n  = 1'b0;
    ppu_oe = 1'b1;
    evq.delete();
    exp_short = 0;
    exp_addr  = 14'd0;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("t6.no_vld", 32'(vld_seen - v0), 32'd0);
    check_idle_outputs("t6");

    // A 20 clk read fires once.
    v0 = vld_seen;
    do_read(14'h1FE8, 20, 1'b0);
    chk("t6.long_once", 32'(vld_seen - v0), 32'd1);
    chk("t6.long_addr", 32'(bus0.fetch_addr), 32'h1FE8);
    check_short("t6.end");
    chk("queue_drained", 32'(evq.size()), 32'd0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
